prf_wb_arbiter: RTL and testbench
=================================

// Module: prf_wb_arbiter
// PURPOSE
//  Writeback arbiter in front of phys_reg_file. Shares the PRF's two write ports (alu port, mem port) among
//  NUM_REQ completing functional units (ALU, branch, LSU by default) using valid/ready handshakes.
//  Round-robin arbitration over requesters. Registered outputs drive the PRF write ports and also serve as
//  the RS wakeup broadcast for the same cycle.
// PARAMETERS
//  NUM_REQ   3   number of FU requesters (index 0=ALU, 1=branch, 2=LSU); legal range 2..8
//  PREG_W    7   physical register tag width (128 PRF entries)
//  DATA_W    32  result width
// PORTS
//  clk            in   1                clock
//  reset          in   1                asynchronous active-high reset
//  flush          in   1                mispredict squash; drops granted-but-unwritten results
//  req_valid      in   NUM_REQ          FU i has a result
//  req_pd         in   NUM_REQ*PREG_W   destination preg of FU i (packed, slice i)
//  req_data       in   NUM_REQ*DATA_W   result of FU i (packed, slice i)
//  req_ready      out  NUM_REQ          FU i result accepted this cycle
//  write_alu_en   out  1                PRF write port 0 enable
//  pd_alu_out     out  PREG_W           PRF write port 0 preg
//  data_alu_out   out  DATA_W           PRF write port 0 data
//  write_mem_en   out  1                PRF write port 1 enable
//  pd_mem_out     out  PREG_W           PRF write port 1 preg
//  data_mem_out   out  DATA_W           PRF write port 1 data
//  stall_cnt      out  32               count of cycles with a valid, ungranted request (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async): write_*_en=0, pd_*_out=0, data_*_out=0, rr_ptr=0, stall_cnt=0. req_ready is combinational and 0 while reset is high.
//  - Arbitration (comb): scan i = rr_ptr, rr_ptr+1, ... mod NUM_REQ. First valid -> port 0, second valid -> port 1.
//    At most 2 grants per cycle. req_ready[i] = grant[i]. Ready depends on valid; FUs must not gate valid on ready.
//  - Handshake: transfer when req_valid[i] && req_ready[i]. An unaccepted FU holds valid/pd/data stable until accepted.
//  - Latency: 1 cycle. The result accepted in cycle N drives the write port in cycle N+1. The PRF captures it at the end of N+1.
//  - Port 0 drives the alu port and port 1 drives the mem port, regardless of which FU was granted.
//  - No grant on a port: en=0, pd/data outputs hold their previous values.
//  - rr_ptr update: if >=1 grant, rr_ptr <= (index of last granted requester + 1) mod NUM_REQ. If no grant, rr_ptr holds.
//  - pd==0 (x0 mapping): the request is granted and accepted (consumes the port slot), but the port's en is driven 0.
//  - Same pd on both grants in one cycle is illegal upstream. The RTL asserts on it in simulation only.
//  - flush=1 in cycle N:
//    - req_ready=0 for all requesters in cycle N.
//    - Both write_*_en=0 in cycle N+1.
//    - Results already on the ports in cycle N are still written.
//    - rr_ptr holds.
//  - flush and reset both high: reset wins.
//  - Reset asserted mid-transfer: the accepted-but-unwritten result is lost. FUs are reset by the same signal.
//  - Wrap-around example: rr_ptr = NUM_REQ-1 scans NUM_REQ-1, 0, 1, ...
//  - Fairness: with all NUM_REQ valid every cycle, every requester is granted within ceil(NUM_REQ/2) cycles.
// CONFIGURATION
//  WB_ARB_PERF_EN defined:
//    - stall_cnt increments (saturating at 2^32-1) every cycle in which any req_valid[i]=1 with req_ready[i]=0, flush cycles included.
//    - stall_cnt is cleared by reset only.
//  WB_ARB_PERF_EN undefined: stall_cnt is tied to 0 and no counter logic is built.
// TESTING
//  1. Single request, {valid=001, pd0=5, data0=0xDEAD_BEEF} -> ready=001. Next cycle write_alu_en=1, pd_alu_out=5, data=0xDEADBEEF, write_mem_en=0.
//  2. All three valid (pd 10/11/12), rr_ptr=0, held valid -> cycle 0 grants 0,1 (ports 0,1); cycle 1 grants 2 to port 0, then 0 to port 1; rr_ptr=1.
//  3. rr_ptr=2, valid=101 -> requester 2 to port 0, requester 0 to port 1; rr_ptr becomes 1. Checks wrap-around.
//  4. Request with pd=0, data=0x1234 -> ready=1. Next cycle write_alu_en=0. No PRF write; read of p0 stays 0.
//  5. flush in the same cycle as valid=011 -> ready=000. Next cycle both write_*_en=0. Requests accepted the cycle after flush drops.
//  6. Perf (WB_ARB_PERF_EN): valid=111 held 4 cycles -> stall_cnt=4. Reset asserted mid-run -> all outputs 0 immediately; stall_cnt=0.

Source files
------------

// File: rtl/prf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// prf_wb_arbiter
//
// Writeback arbiter in front of the physical register file. NUM_REQ
// completing functional units compete for the PRF's two write ports using
// valid/ready handshakes. A round-robin scan, starting at rr_ptr, grants the
// first valid requester to port 0 (alu port) and the second to port 1 (mem
// port). Accepted results are registered, so a result accepted in cycle N
// drives the write port in cycle N+1. The same registered outputs also act as
// the RS wakeup broadcast.
//
// Optional feature macro: WB_ARB_PERF_EN
//   defined   -> stall_cnt counts cycles with a valid but unaccepted request
//   undefined -> stall_cnt is tied to 0 and no counter is built
//
// Ports
//   clk           in   clock
//   reset         in   asynchronous active-high reset
//   flush         in   mispredict squash: no grants this cycle
//   req_valid     in   [NUM_REQ]         FU i has a result
//   req_pd        in   [NUM_REQ*PREG_W]  destination preg of FU i (slice i)
//   req_data      in   [NUM_REQ*DATA_W]  result of FU i (slice i)
//   req_ready     out  [NUM_REQ]         FU i result accepted this cycle
//   write_alu_en  out  PRF write port 0 enable
//   pd_alu_out    out  PRF write port 0 preg
//   data_alu_out  out  PRF write port 0 data
//   write_mem_en  out  PRF write port 1 enable
//   pd_mem_out    out  PRF write port 1 preg
//   data_mem_out  out  PRF write port 1 data
//   stall_cnt     out  [32] stall cycle counter (see macro above)
// -----------------------------------------------------------------------------
module prf_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int PREG_W  = 7,
    parameter int DATA_W  = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*PREG_W-1:0]   req_pd,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        write_alu_en,
    output logic [PREG_W-1:0]           pd_alu_out,
    output logic [DATA_W-1:0]           data_alu_out,
    output logic                        write_mem_en,
    output logic [PREG_W-1:0]           pd_mem_out,
    output logic [DATA_W-1:0]           data_mem_out,
    output logic [31:0]                 stall_cnt
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SUM_W = PTR_W + 1;

    // Unpacked views of the packed request buses.
    logic [PREG_W-1:0] pd_arr   [NUM_REQ];
    logic [DATA_W-1:0] data_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign pd_arr[g]   = req_pd[g*PREG_W +: PREG_W];
        assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
    end

    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               alu_en_q, alu_en_d, mem_en_q, mem_en_d;
    logic [PREG_W-1:0]  alu_pd_q, alu_pd_d, mem_pd_q, mem_pd_d;
    logic [DATA_W-1:0]  alu_data_q, alu_data_d, mem_data_q, mem_data_d;

    logic [NUM_REQ-1:0] grant;
    logic               g0_v, g1_v;
    logic [PTR_W-1:0]   g0_idx, g1_idx, last_idx, idx;
    logic [SUM_W-1:0]   sum;

    // Round-robin scan: rr_ptr, rr_ptr+1, ... wrapping at NUM_REQ.
    // Reset and flush suppress every grant, so ready is low in those cycles.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned; a missing default here would infer a latch.
        grant    = '0;
        g0_v     = 1'b0;
        g1_v     = 1'b0;
        g0_idx   = '0;
        g1_idx   = '0;
        last_idx = rr_ptr_q;
        sum      = '0;
        idx      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr_q} + SUM_W'(k);
            if (sum >= SUM_W'(NUM_REQ)) begin
                sum = sum - SUM_W'(NUM_REQ);
            end
            idx = sum[PTR_W-1:0];
            if (req_valid[idx] && !reset && !flush) begin
                if (!g0_v) begin
                    g0_v       = 1'b1;
                    g0_idx     = idx;
                    grant[idx] = 1'b1;
                    last_idx   = idx;
                end else if (!g1_v) begin
                    g1_v       = 1'b1;
                    g1_idx     = idx;
                    grant[idx] = 1'b1;
                    last_idx   = idx;
                end
            end
        end
    end

    assign req_ready = grant;

    // Next-state for the write ports and the pointer. A grant with pd==0
    // (architectural x0) still consumes the slot but never enables the write.
    always_comb begin
        alu_en_d   = g0_v && (pd_arr[g0_idx] != '0);
        alu_pd_d   = g0_v ? pd_arr[g0_idx]   : alu_pd_q;
        alu_data_d = g0_v ? data_arr[g0_idx] : alu_data_q;
        mem_en_d   = g1_v && (pd_arr[g1_idx] != '0);
        mem_pd_d   = g1_v ? pd_arr[g1_idx]   : mem_pd_q;
        mem_data_d = g1_v ? data_arr[g1_idx] : mem_data_q;
        rr_ptr_d   = rr_ptr_q;
        if (g0_v) begin
            rr_ptr_d = (last_idx == PTR_W'(NUM_REQ - 1)) ? '0 : last_idx + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q   <= '0;
            alu_en_q   <= 1'b0;
            alu_pd_q   <= '0;
            alu_data_q <= '0;
            mem_en_q   <= 1'b0;
            mem_pd_q   <= '0;
            mem_data_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            alu_en_q   <= alu_en_d;
            alu_pd_q   <= alu_pd_d;
            alu_data_q <= alu_data_d;
            mem_en_q   <= mem_en_d;
            mem_pd_q   <= mem_pd_d;
            mem_data_q <= mem_data_d;
        end
    end

    assign write_alu_en = alu_en_q;
    assign pd_alu_out   = alu_pd_q;
    assign data_alu_out = alu_data_q;
    assign write_mem_en = mem_en_q;
    assign pd_mem_out   = mem_pd_q;
    assign data_mem_out = mem_data_q;

`ifdef WB_ARB_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of cycles where some valid request was not accepted.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (|(req_valid & ~grant) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

`ifndef SYNTHESIS
    // Two real (non-x0) writes to the same preg in one cycle is an upstream bug.
    dup_pd_a: assert property (@(posedge clk) disable iff (reset)
        !(g1_v && (pd_arr[g0_idx] == pd_arr[g1_idx]) && (pd_arr[g0_idx] != '0)));
`endif

endmodule

// File: tb/tb_prf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_prf_wb_arbiter
//
// Directed testbench for prf_wb_arbiter (NUM_REQ=3, PREG_W=7, DATA_W=32).
// Inputs change on the falling edge; combinational ready is sampled #1 later
// and registered outputs are sampled on the falling edge after the capture.
// -----------------------------------------------------------------------------
module tb_prf_wb_arbiter;

    localparam int N  = 3;
    localparam int PW = 7;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic [N-1:0]      req_valid;
    logic [N*PW-1:0]   req_pd;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic              write_alu_en;
    logic [PW-1:0]     pd_alu_out;
    logic [DW-1:0]     data_alu_out;
    logic              write_mem_en;
    logic [PW-1:0]     pd_mem_out;
    logic [DW-1:0]     data_mem_out;
    logic [31:0]       stall_cnt;

    int passed = 0;
    int total  = 0;

`ifdef WB_ARB_PERF_EN
    localparam logic [31:0] EXP_STALL4 = 32'd4;
`else
    localparam logic [31:0] EXP_STALL4 = 32'd0;
`endif

    prf_wb_arbiter #(.NUM_REQ(N), .PREG_W(PW), .DATA_W(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .req_valid    (req_valid),
        .req_pd       (req_pd),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .write_alu_en (write_alu_en),
        .pd_alu_out   (pd_alu_out),
        .data_alu_out (data_alu_out),
        .write_mem_en (write_mem_en),
        .pd_mem_out   (pd_mem_out),
        .data_mem_out (data_mem_out),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic set_req(input int i, input logic v, input logic [PW-1:0] pd,
                           input logic [DW-1:0] d);
        req_valid[i]         = v;
        req_pd[i*PW +: PW]   = pd;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic idle();
        req_valid = '0;
        flush     = 1'b0;
    endtask

    // Advance one cycle, landing on the next falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; req_valid = '0; req_pd = '0; req_data = '0;
        @(negedge clk);
        req_valid = 3'b111;
        #1;
        total++; if (req_ready !== 3'b000) $display("FAIL reset_ready got=%b exp=000", req_ready); else passed++;
        total++; if ({write_alu_en, write_mem_en} !== 2'b00) $display("FAIL reset_en got=%b exp=00", {write_alu_en, write_mem_en}); else passed++;
        total++; if ({pd_alu_out, pd_mem_out, data_alu_out, data_mem_out} !== '0) $display("FAIL reset_pd_data got=%h exp=0", {pd_alu_out, pd_mem_out, data_alu_out, data_mem_out}); else passed++;
        total++; if (stall_cnt !== 32'd0) $display("FAIL reset_stall got=%0d exp=0", stall_cnt); else passed++;
        @(negedge clk);
        reset = 1'b0;
        idle();
        tick();
    endtask

    // rr_ptr=0, all three valid with pd 10/11/12.
    task automatic test_round_robin();
        set_req(0, 1'b1, 7'd10, 32'hA0); set_req(1, 1'b1, 7'd11, 32'hA1); set_req(2, 1'b1, 7'd12, 32'hA2);
        #1;
        total++; if (req_ready !== 3'b011) $display("FAIL rr_c0_ready got=%b exp=011", req_ready); else passed++;
        tick();
        #1;
        total++; if (req_ready !== 3'b101) $display("FAIL rr_c1_ready got=%b exp=101", req_ready); else passed++;
        total++; if ({write_alu_en, pd_alu_out, data_alu_out} !== {1'b1, 7'd10, 32'hA0}) $display("FAIL rr_c1_alu got=%b/%0d/%h exp=1/10/a0", write_alu_en, pd_alu_out, data_alu_out); else passed++;
        total++; if ({write_mem_en, pd_mem_out, data_mem_out} !== {1'b1, 7'd11, 32'hA1}) $display("FAIL rr_c1_mem got=%b/%0d/%h exp=1/11/a1", write_mem_en, pd_mem_out, data_mem_out); else passed++;
        tick();
        #1;
        total++; if ({pd_alu_out, data_alu_out} !== {7'd12, 32'hA2}) $display("FAIL rr_c2_alu got=%0d/%h exp=12/a2", pd_alu_out, data_alu_out); else passed++;
        total++; if ({pd_mem_out, data_mem_out} !== {7'd10, 32'hA0}) $display("FAIL rr_c2_mem got=%0d/%h exp=10/a0", pd_mem_out, data_mem_out); else passed++;
        // rr_ptr is now 1: scan starts at requester 1.
        total++; if (req_ready !== 3'b110) $display("FAIL rr_ptr1_ready got=%b exp=110", req_ready); else passed++;
        idle();
        tick();
        total++; if ({write_alu_en, write_mem_en} !== 2'b00) $display("FAIL rr_idle_en got=%b exp=00", {write_alu_en, write_mem_en}); else passed++;
    endtask

    task automatic test_single();
        set_req(0, 1'b1, 7'd5, 32'hDEAD_BEEF);
        #1;
        total++; if (req_ready !== 3'b001) $display("FAIL single_ready got=%b exp=001", req_ready); else passed++;
        tick();
        idle();
        total++; if ({write_alu_en, pd_alu_out, data_alu_out} !== {1'b1, 7'd5, 32'hDEAD_BEEF}) $display("FAIL single_alu got=%b/%0d/%h exp=1/5/deadbeef", write_alu_en, pd_alu_out, data_alu_out); else passed++;
        total++; if (write_mem_en !== 1'b0) $display("FAIL single_mem_en got=%b exp=0", write_mem_en); else passed++;
        tick();
        total++; if ({write_alu_en, pd_alu_out, data_alu_out} !== {1'b0, 7'd5, 32'hDEAD_BEEF}) $display("FAIL single_hold got=%b/%0d/%h exp=0/5/deadbeef", write_alu_en, pd_alu_out, data_alu_out); else passed++;
    endtask

    // rr_ptr=1 on entry; requester 1 alone moves rr_ptr to 2, then wrap.
    task automatic test_wrap();
        set_req(1, 1'b1, 7'd20, 32'hB1);
        tick();
        idle();
        set_req(0, 1'b1, 7'd21, 32'hC0); set_req(2, 1'b1, 7'd22, 32'hC2);
        #1;
        total++; if (req_ready !== 3'b101) $display("FAIL wrap_ready got=%b exp=101", req_ready); else passed++;
        tick();
        total++; if ({pd_alu_out, data_alu_out, pd_mem_out, data_mem_out} !== {7'd22, 32'hC2, 7'd21, 32'hC0}) $display("FAIL wrap_ports got=%0d/%h %0d/%h exp=22/c2 21/c0", pd_alu_out, data_alu_out, pd_mem_out, data_mem_out); else passed++;
        // rr_ptr should now be 1.
        set_req(0, 1'b1, 7'd23, 32'hD0); set_req(1, 1'b1, 7'd24, 32'hD1); set_req(2, 1'b1, 7'd25, 32'hD2);
        #1;
        total++; if (req_ready !== 3'b110) $display("FAIL wrap_ptr_ready got=%b exp=110", req_ready); else passed++;
        tick();
        idle();
        total++; if ({pd_alu_out, pd_mem_out} !== {7'd24, 7'd25}) $display("FAIL wrap_ptr_ports got=%0d/%0d exp=24/25", pd_alu_out, pd_mem_out); else passed++;
        tick();
    endtask

    // rr_ptr=0 on entry. pd==0 on requester 0 consumes port 0 with no write.
    task automatic test_pd_zero();
        set_req(0, 1'b1, 7'd0, 32'h1234); set_req(1, 1'b1, 7'd30, 32'h30);
        #1;
        total++; if (req_ready !== 3'b011) $display("FAIL pd0_ready got=%b exp=011", req_ready); else passed++;
        tick();
        idle();
        total++; if (write_alu_en !== 1'b0) $display("FAIL pd0_alu_en got=%b exp=0", write_alu_en); else passed++;
        total++; if ({write_mem_en, pd_mem_out, data_mem_out} !== {1'b1, 7'd30, 32'h30}) $display("FAIL pd0_mem got=%b/%0d/%h exp=1/30/30", write_mem_en, pd_mem_out, data_mem_out); else passed++;
        tick();
    endtask

    // rr_ptr=2 on entry.
    task automatic test_flush();
        set_req(2, 1'b1, 7'd40, 32'h40);
        tick();
        idle();
        flush = 1'b1;
        set_req(0, 1'b1, 7'd41, 32'h41); set_req(1, 1'b1, 7'd42, 32'h42);
        #1;
        total++; if (req_ready !== 3'b000) $display("FAIL flush_ready got=%b exp=000", req_ready); else passed++;
        total++; if ({write_alu_en, pd_alu_out} !== {1'b1, 7'd40}) $display("FAIL flush_inflight got=%b/%0d exp=1/40", write_alu_en, pd_alu_out); else passed++;
        tick();
        flush = 1'b0;
        #1;
        total++; if ({write_alu_en, write_mem_en} !== 2'b00) $display("FAIL flush_next_en got=%b exp=00", {write_alu_en, write_mem_en}); else passed++;
        total++; if (req_ready !== 3'b011) $display("FAIL flush_after_ready got=%b exp=011", req_ready); else passed++;
        tick();
        idle();
        total++; if ({write_alu_en, pd_alu_out, write_mem_en, pd_mem_out} !== {1'b1, 7'd41, 1'b1, 7'd42}) $display("FAIL flush_after_ports got=%b/%0d %b/%0d exp=1/41 1/42", write_alu_en, pd_alu_out, write_mem_en, pd_mem_out); else passed++;
        tick();
    endtask

    task automatic test_perf_and_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        set_req(0, 1'b1, 7'd10, 32'hE0); set_req(1, 1'b1, 7'd11, 32'hE1); set_req(2, 1'b1, 7'd12, 32'hE2);
        repeat (4) tick();
        total++; if (stall_cnt !== EXP_STALL4) $display("FAIL perf_stall4 got=%0d exp=%0d", stall_cnt, EXP_STALL4); else passed++;
        total++; if ({write_alu_en, write_mem_en} !== 2'b11) $display("FAIL perf_en got=%b exp=11", {write_alu_en, write_mem_en}); else passed++;
        #2;
        reset = 1'b1;
        #1;
        total++; if ({write_alu_en, write_mem_en, pd_alu_out, pd_mem_out, data_alu_out, data_mem_out} !== '0) $display("FAIL midreset_outputs got=%h exp=0", {write_alu_en, write_mem_en, pd_alu_out, pd_mem_out, data_alu_out, data_mem_out}); else passed++;
        total++; if (req_ready !== 3'b000) $display("FAIL midreset_ready got=%b exp=000", req_ready); else passed++;
        total++; if (stall_cnt !== 32'd0) $display("FAIL midreset_stall got=%0d exp=0", stall_cnt); else passed++;
        idle();
        @(negedge clk);
        reset = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_wrap();
        test_pd_zero();
        test_flush();
        test_perf_and_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
